// File: rtl/awg_pkg.sv
// Shared definitions for the arbitrary-waveform playback controller:
// command opcodes, controller states and the DAC mid-scale code.
package awg_pkg;

  typedef enum logic [1:0] {
    OP_SET_DIV = 2'b00,
    OP_SET_LEN = 2'b01,
    OP_START   = 2'b10,
    OP_STOP    = 2'b11
  } awg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } awg_state_e;

  localparam logic [7:0] MIDSCALE = 8'h80;

endpackage

// File: rtl/awg_rate_div.sv
// Loadable down-counter that paces sample reads. tick is high while counting
// is enabled and the counter sits at zero; on that cycle the counter reloads.
module awg_rate_div
  import awg_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = en && (count == '0);

  // Count down while enabled and reload on zero; clear parks the counter at
  // zero so the first tick comes on the very next enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == '0) begin
        count <= load_val;
      end else begin
        count <= count - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/awg_playback_ctrl.sv
// Playback controller for a small arbitrary-waveform generator. Commands set
// the rate divider and the last sample address, start and stop playback.
// While running, samples are read from memory at a divided rate, and each
// returned byte is held on sample_out until the next one arrives.
module awg_playback_ctrl
  import awg_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        sample_out,
  output logic              sample_strobe,
  output logic              busy,
  output logic              wrap
);

  awg_state_e        state;
  awg_op_e           op;

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] len_sh;
  logic [ADDR_W-1:0] len_eff;
  logic [ADDR_W-1:0] cmd_len;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_sh;
  logic [DIV_W-1:0]  load_val;
  logic [DIV_W-1:0]  cmd_div;
  logic              div_sh_v;
  logic              len_sh_v;
  logic              wrap_pend;
  logic              cap_pend;

  logic              cmd_fire;
  logic              is_start;
  logic              is_stop;
  logic              is_set_div;
  logic              is_set_len;
  logic              run_en;
  logic              tick;
  logic              issue;
  logic              wrap_now;

  assign op         = awg_op_e'(cmd_op);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign is_start   = cmd_fire && (op == OP_START);
  assign is_stop    = cmd_fire && (op == OP_STOP);
  assign is_set_div = cmd_fire && (op == OP_SET_DIV);
  assign is_set_len = cmd_fire && (op == OP_SET_LEN);
  assign cmd_div    = DIV_W'(cmd_data);
  assign cmd_len    = ADDR_W'(cmd_data);

  // A start or stop in the same cycle as a tick wins over the read.
  assign run_en   = (state == ST_RUN) && ena;
  assign issue    = tick && !is_start && !is_stop;
  assign wrap_now = issue && wrap_pend;

  // On the wrap read the pending shadow values take effect immediately, so
  // the reload and the end-of-table compare already use the new settings.
  assign load_val = (wrap_now && div_sh_v) ? div_sh : div_reg;
  assign len_eff  = (wrap_now && len_sh_v) ? len_sh : len_reg;

  awg_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (run_en),
    .clear    (is_start),
    .load_val (load_val),
    .tick     (tick)
  );

  // Controller state with registered busy and cmd_ready; DRAIN waits for the
  // capture of the last issued read before returning to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (is_start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (is_stop) begin
            if (mem_rd) begin
              state     <= ST_DRAIN;
              cmd_ready <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (cap_pend) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cmd_ready <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read pointer and memory strobe; the wrap pulse rides on the first read
  // after the pointer has rolled back to address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      wrap      <= 1'b0;
      wrap_pend <= 1'b0;
    end else begin
      mem_rd <= issue;
      wrap   <= wrap_now;
      if (is_start) begin
        rd_ptr    <= '0;
        wrap_pend <= 1'b0;
      end else if (issue) begin
        mem_addr  <= rd_ptr;
        wrap_pend <= (rd_ptr == len_eff);
        rd_ptr    <= (rd_ptr == len_eff) ? '0 : rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Divider and length settings: written directly while idle, staged in
  // shadows while running and promoted on the wrap read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg  <= '0;
      len_reg  <= '1;
      div_sh   <= '0;
      len_sh   <= '0;
      div_sh_v <= 1'b0;
      len_sh_v <= 1'b0;
    end else begin
      if (wrap_now && div_sh_v) begin
        div_reg  <= div_sh;
        div_sh_v <= 1'b0;
      end
      if (wrap_now && len_sh_v) begin
        len_reg  <= len_sh;
        len_sh_v <= 1'b0;
      end
      if (is_set_div) begin
        if (state == ST_IDLE) begin
          div_reg <= cmd_div;
        end else begin
          div_sh   <= cmd_div;
          div_sh_v <= 1'b1;
        end
      end
      if (is_set_len) begin
        if (state == ST_IDLE) begin
          len_reg <= cmd_len;
        end else begin
          len_sh   <= cmd_len;
          len_sh_v <= 1'b1;
        end
      end
      if (is_start) begin
        div_sh_v <= 1'b0;
        len_sh_v <= 1'b0;
      end
    end
  end

  // Sample capture: memory data is valid the cycle after the read strobe and
  // is latched at the end of that cycle, with a one-cycle update strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_pend      <= 1'b0;
      sample_out    <= MIDSCALE;
      sample_strobe <= 1'b0;
    end else begin
      cap_pend      <= mem_rd;
      sample_strobe <= cap_pend;
      if (cap_pend) begin
        sample_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_awg_playback_ctrl.sv
// Self-checking bench for awg_playback_ctrl: directed playback scenarios and
// a randomized command stream, compared each cycle against a behavioural
// model of the controller kept in this file.
module tb_awg_playback_ctrl;
  import awg_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_data;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic [7:0]        sample_out;
  logic              sample_strobe;
  logic              busy;
  logic              wrap;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: mode 0 idle, 1 playing, 2 draining
  int m_mode, m_wait, m_ptr, m_div, m_len, m_sdiv, m_slen;
  bit m_sdiv_v, m_slen_v, m_wrapped;
  bit e_rd, e_wrap, e_strobe, e_busy, e_ready;
  int e_addr, e_sample;
  bit cap_due;
  int cap_addr;

  // Observation logs for the directed scenarios
  int rd_cyc[$];
  int rd_addr[$];
  int rd_wrap[$];
  int st_cyc[$];
  int st_val[$];

  always #5 clk = ~clk;

  awg_playback_ctrl #(
    .ADDR_W (ADDR_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .wrap          (wrap)
  );

  function automatic int mem_fn(input int a);
    return (a + 16) & 255;
  endfunction

  // Sample memory: data for a strobed address appears the following cycle
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= 8'(mem_fn(int'(mem_addr)));
  end

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_ptr = 0; m_div = 0; m_len = 63;
    m_sdiv = 0; m_slen = 0; m_sdiv_v = 0; m_slen_v = 0; m_wrapped = 0;
    e_rd = 0; e_addr = 0; e_wrap = 0; e_strobe = 0; e_sample = 128;
    e_busy = 0; e_ready = 0; cap_due = 0; cap_addr = 0;
  endtask

  // Advance the model across one rising edge given that cycle's inputs
  task automatic model_edge(input bit v, input int op, input int d, input bit en, input bit rstn);
    bit fire, n_rd, n_wrap, n_strobe;
    int n_addr, n_sample;
    if (!rstn) begin
      model_reset();
      return;
    end
    fire     = v && e_ready;
    n_strobe = cap_due;
    n_sample = cap_due ? mem_fn(cap_addr) : e_sample;
    cap_due  = e_rd;
    cap_addr = e_addr;
    n_rd = 0; n_wrap = 0; n_addr = e_addr;
    if (m_mode == 1 && en && !(fire && (op == 2 || op == 3))) begin
      if (m_wait == 0) begin
        n_rd   = 1;
        n_addr = m_ptr;
        n_wrap = m_wrapped;
        if (m_wrapped) begin
          if (m_sdiv_v) begin m_div = m_sdiv; m_sdiv_v = 0; end
          if (m_slen_v) begin m_len = m_slen; m_slen_v = 0; end
        end
        m_wrapped = (m_ptr == m_len);
        m_ptr     = m_wrapped ? 0 : m_ptr + 1;
        m_wait    = m_div;
      end else begin
        m_wait--;
      end
    end
    if (m_mode == 2 && n_strobe) m_mode = 0;
    if (fire) begin
      case (op)
        0: if (m_mode == 0) m_div = d & 255; else begin m_sdiv = d & 255; m_sdiv_v = 1; end
        1: if (m_mode == 0) m_len = d & 63;  else begin m_slen = d & 63;  m_slen_v = 1; end
        2: begin
          m_mode = 1; m_ptr = 0; m_wait = 0; m_wrapped = 0; m_sdiv_v = 0; m_slen_v = 0;
        end
        default: if (m_mode == 1) m_mode = e_rd ? 2 : 0;
      endcase
    end
    e_rd = n_rd; e_addr = n_addr; e_wrap = n_wrap;
    e_strobe = n_strobe; e_sample = n_sample;
    e_ready = (m_mode != 2);
    e_busy  = (m_mode != 0);
  endtask

  task automatic compare_all();
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("mem_rd", 32'(mem_rd), 32'(e_rd));
    checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
    checkOutput("wrap", 32'(wrap), 32'(e_wrap));
    checkOutput("sample_strobe", 32'(sample_strobe), 32'(e_strobe));
    checkOutput("sample_out", 32'(sample_out), 32'(e_sample));
    if (mem_rd) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(int'(mem_addr));
      rd_wrap.push_back(int'(wrap));
    end
    if (sample_strobe) begin
      st_cyc.push_back(cyc);
      st_val.push_back(int'(sample_out));
    end
  endtask

  // One cycle: check the current outputs, drive this cycle's inputs, step the model
  task automatic applyStimulus(input bit v, input int op, input int d, input bit en, input bit rstn);
    compare_all();
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_data  = 8'(d);
    ena       = en;
    rst_n     = rstn;
    @(posedge clk);
    model_edge(v, op, d, en, rstn);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cycles(input int n, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, en, 1'b1);
  endtask

  task automatic send(input int op, input int d);
    applyStimulus(1'b1, op, d, 1'b1, 1'b1);
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); rd_wrap.delete();
    st_cyc.delete(); st_val.delete();
  endtask

  initial begin
    int t0, idx, quiet, r, op, d;
    bit v, en, rn;

    rst_n = 1'b0; ena = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    run_cycles(2, 1'b1);

    // Divider 3, four-entry table: reads every 4 cycles, wrap on second address 0
    send(OP_SET_DIV, 3);
    send(OP_SET_LEN, 3);
    clear_logs();
    t0 = cyc;
    send(OP_START, 0);
    run_cycles(20, 1'b1);
    checkOutput("s1_read_count", 32'(rd_cyc.size() >= 5), 1);
    if (rd_cyc.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("s1_cycle%0d", i), rd_cyc[i] - t0, 2 + 4 * i);
        checkOutput($sformatf("s1_addr%0d", i), rd_addr[i], (i == 4) ? 0 : i);
        checkOutput($sformatf("s1_wrap%0d", i), rd_wrap[i], (i == 4) ? 1 : 0);
      end
    end
    send(OP_STOP, 0);
    run_cycles(3, 1'b1);

    // Back-to-back reads, then STOP coinciding with a read to exercise DRAIN
    send(OP_SET_DIV, 0);
    send(OP_SET_LEN, 63);
    clear_logs();
    t0 = cyc;
    send(OP_START, 0);
    run_cycles(8, 1'b1);
    checkOutput("s2_strobe_count", 32'(st_cyc.size() >= 4), 1);
    if (st_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("s2_value%0d", i), st_val[i], 16 + i);
        checkOutput($sformatf("s2_scycle%0d", i), st_cyc[i] - t0, 4 + i);
      end
    end
    send(OP_STOP, 0);
    checkOutput("s3_drain_ready", 32'(cmd_ready), 0);
    checkOutput("s3_drain_busy", 32'(busy), 1);
    run_cycles(1, 1'b1);
    checkOutput("s3_final_strobe", 32'(sample_strobe), 1);
    checkOutput("s3_final_value", 32'(sample_out), 32'h17);
    checkOutput("s3_idle_busy", 32'(busy), 0);
    checkOutput("s3_idle_ready", 32'(cmd_ready), 1);
    run_cycles(3, 1'b1);
    checkOutput("s3_hold_value", 32'(sample_out), 32'h17);
    checkOutput("s3_hold_strobe", 32'(sample_strobe), 0);

    // Divider change while running takes effect only from the wrap read
    send(OP_SET_DIV, 1);
    send(OP_SET_LEN, 7);
    clear_logs();
    t0 = cyc;
    send(OP_START, 0);
    run_cycles(5, 1'b1);
    send(OP_SET_DIV, 7);
    run_cycles(40, 1'b1);
    checkOutput("s4_read_count", 32'(rd_cyc.size() >= 11), 1);
    if (rd_cyc.size() >= 11) begin
      checkOutput("s4_period_before", rd_cyc[8] - rd_cyc[7], 2);
      checkOutput("s4_wrap_addr", rd_addr[8], 0);
      checkOutput("s4_wrap_flag", rd_wrap[8], 1);
      checkOutput("s4_period_after1", rd_cyc[9] - rd_cyc[8], 8);
      checkOutput("s4_period_after2", rd_cyc[10] - rd_cyc[9], 8);
    end
    send(OP_STOP, 0);
    run_cycles(3, 1'b1);

    // Enable low for 5 cycles mid-run: no reads, resume at the next address
    send(OP_SET_DIV, 2);
    send(OP_SET_LEN, 63);
    clear_logs();
    t0 = cyc;
    send(OP_START, 0);
    run_cycles(7, 1'b1);
    run_cycles(5, 1'b0);
    run_cycles(12, 1'b1);
    idx = -1;
    quiet = 0;
    foreach (rd_cyc[i]) begin
      if (rd_cyc[i] >= t0 + 9 && rd_cyc[i] <= t0 + 13) quiet++;
      if (idx < 0 && rd_cyc[i] > t0 + 8) idx = i;
    end
    checkOutput("s5_quiet_reads", quiet, 0);
    checkOutput("s5_resume_found", 32'(idx >= 0), 1);
    if (idx >= 0) begin
      checkOutput("s5_resume_cycle", rd_cyc[idx] - t0, 16);
      checkOutput("s5_resume_addr", rd_addr[idx], 3);
    end
    send(OP_STOP, 0);
    run_cycles(3, 1'b1);

    // One-cycle reset while a read is in flight
    send(OP_SET_DIV, 1);
    send(OP_START, 0);
    run_cycles(2, 1'b1);
    for (int i = 0; i < 8 && !mem_rd; i++) run_cycles(1, 1'b1);
    checkOutput("s6_read_pending", 32'(mem_rd), 1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("s6_rst_sample", 32'(sample_out), 32'h80);
    checkOutput("s6_rst_busy", 32'(busy), 0);
    checkOutput("s6_rst_strobe", 32'(sample_strobe), 0);
    checkOutput("s6_rst_ready", 32'(cmd_ready), 0);
    run_cycles(1, 1'b1);
    checkOutput("s6_ready_after", 32'(cmd_ready), 1);
    checkOutput("s6_no_late_strobe", 32'(sample_strobe), 0);
    checkOutput("s6_sample_after", 32'(sample_out), 32'h80);
    run_cycles(2, 1'b1);

    // Randomized command stream with occasional enable drops and resets
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 99) < 30);
      r  = $urandom_range(0, 99);
      op = (r < 25) ? 2 : (r < 37) ? 3 : (r < 70) ? 0 : 1;
      d  = (op == 0) ? $urandom_range(0, 4) : $urandom_range(0, 12);
      en = ($urandom_range(0, 99) < 85);
      rn = ($urandom_range(0, 99) >= 2);
      applyStimulus(v, op, d, en, rn);
    end
    run_cycles(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
